bist_misr_ctrl: RTL and testbench
=================================

Name: bist_misr_ctrl

Overview:
- Built-in self-test stage that wraps a registered circuit-under-test built from dff/dff_r cells.
- Upstream half: Galois LFSR pattern generator that drives the data inputs of the CUT flops.
- Downstream half: multiple-input signature register (MISR) that compacts the flopped CUT responses one cycle later.
- An FSM sequences seed load, pattern run, final flush and pass/fail compare against a golden signature.

Parameters:
- WIDTH, 8: pattern, response and signature width (2..32).
- POLY, 8'hB8: Galois feedback mask, shared by the LFSR and the MISR.
- SEED, 8'h01: LFSR start value; must be non-zero.
- PATTERNS, 16: number of patterns applied per run (1..2^WIDTH-1).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; sampled on the rising clock edge.
- start  in  1  request a BIST run; level-sampled.
- golden  in  WIDTH  expected signature; sampled in DONE.
- response  in  WIDTH  CUT outputs, already registered (one-cycle latency from pattern).
- pattern  out  WIDTH  stimulus to the CUT flop data inputs.
- busy  out  1  high in LOAD, RUN and FLUSH.
- done  out  1  high in DONE.
- pass  out  1  in DONE, (signature == golden); otherwise 0.
- signature  out  WIDTH  MISR contents.

Behaviour:
- Step function: step(x) = (x >> 1) ^ (x[0] ? POLY : 0).
- LFSR update: lfsr <= step(lfsr).
- MISR update: misr <= step(misr) ^ response.
- States: IDLE, LOAD, RUN, FLUSH, DONE.
- Reset (reset==0 at a rising edge): state=IDLE, lfsr=SEED, misr=0, count=0, capture=0. All outputs read 0 in the following cycle. Reset wins over every other event, including mid-run; the run is abandoned.
- IDLE: start=1 -> LOAD.
- LOAD (1 cycle): lfsr<=SEED, misr<=0, count<=0 -> RUN.
- RUN (exactly PATTERNS cycles):
  - pattern = lfsr (combinational from register); lfsr steps each cycle; count increments.
  - Leave for FLUSH when count == PATTERNS-1.
- pattern = 0 in every state other than RUN.
- capture flag: registered copy of (state==RUN). The MISR updates on every cycle where capture=1, which gives exactly PATTERNS updates, the last one in FLUSH.
- FLUSH (1 cycle) -> DONE.
- DONE:
  - done=1; pass compares the current golden input to signature combinationally.
  - The state holds until start=1, which goes to LOAD (back-to-back runs allowed; the MISR is cleared in LOAD).
- start is ignored in LOAD, RUN and FLUSH. No abort input; reset is the only abort.
- signature is visible in all states. It holds its final value in DONE and returns to 0 in IDLE only through reset.
- count width: clog2(PATTERNS+1). No wrap inside a run.
- The LFSR wraps naturally with period 2^WIDTH-1 for a primitive POLY. A POLY that is not primitive is legal; the sequence is simply shorter.
- Total latency from start=1 to done=1 is PATTERNS+3 cycles (LOAD, RUN×PATTERNS, FLUSH, then DONE).

Decomposition:
- Shared package/include (bist_defs):
  - state encoding constants (IDLE=0, LOAD=1, RUN=2, FLUSH=3, DONE=4, 3 bits);
  - default POLY/SEED constants;
  - a galois_step function parameterised by WIDTH.
- One sub-module, galois_reg (WIDTH, POLY):
  - a register with load, step-enable and XOR-in ports;
  - instantiated twice: as the LFSR (XOR-in tied 0) and as the MISR.
- The FSM and counter stay in the top module.

Test Plan (WIDTH=4, POLY=4'hC, SEED=4'h1 unless stated):
- LFSR sequence: PATTERNS=15, response tied 0 -> pattern in RUN cycles 0..14 = 1,C,6,3,D,A,5,E,7,F,B,9,8,4,2; signature=0; done 18 cycles after start.
- Loopback: response = pattern passed through dff, PATTERNS=3, golden=4'h6 -> signature=4'h6, pass=1. With golden=4'h5 -> pass=0, done=1.
- Stray start: start held high through RUN -> no restart, exactly 3 MISR updates. Start in DONE -> LOAD next cycle; signature cleared to 0 in LOAD, and the second run yields 4'h6 again.
- Reset mid-RUN: drive reset=0 in RUN cycle 1 -> next cycle state=IDLE, busy=done=pass=0, pattern=0, signature=0. A later start gives a clean 4'h6.
- Reset synchronicity: pulse reset=0 between clock edges only -> no effect. Reset=0 coincident with start in IDLE -> stays IDLE.
- PATTERNS=1 boundary: loopback -> single pattern 1, signature=4'h1, done 4 cycles after start.

Source files
------------

// File: rtl/bist_misr_ctrl_pkg.sv
// Shared definitions for the BIST pattern/signature controller:
// FSM state encoding, default polynomial/seed and the Galois step.
package bist_misr_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [7:0] DEFAULT_POLY = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'h01;

    // Width-agnostic: callers zero-extend to 32 bits and truncate back.
    function automatic logic [31:0] galois_step(
        input logic [31:0] x,
        input logic [31:0] poly
    );
        return (x >> 1) ^ (x[0] ? poly : 32'd0);
    endfunction

endpackage

// File: rtl/bist_misr_ctrl_galois_reg.sv
// Galois shift register with load, step enable and XOR-in.
// Used both as the pattern LFSR and as the response MISR.
module galois_reg
    import bist_misr_ctrl_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] POLY      = WIDTH'(DEFAULT_POLY),
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             step_en,
    input  logic [WIDTH-1:0] xor_in,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] stepped;

    assign stepped = WIDTH'(galois_step(32'(value), 32'(POLY)));

    // Reset beats load, load beats a step.
    always_ff @(posedge clock) begin
        if (!reset) begin
            value <= RESET_VAL;
        end else if (load) begin
            value <= load_value;
        end else if (step_en) begin
            value <= stepped ^ xor_in;
        end
    end

endmodule

// File: rtl/bist_misr_ctrl.sv
// BIST stage: LFSR drives CUT flops, MISR compacts their responses,
// FSM sequences load/run/flush and compares against a golden signature.
module bist_misr_ctrl
    import bist_misr_ctrl_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] POLY     = WIDTH'(DEFAULT_POLY),
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(DEFAULT_SEED),
    parameter int               PATTERNS = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] golden,
    input  logic [WIDTH-1:0] response,
    output logic [WIDTH-1:0] pattern,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    localparam int            CW   = $clog2(PATTERNS + 1);
    localparam logic [CW-1:0] LAST = CW'(PATTERNS - 1);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic             capture;
    logic [WIDTH-1:0] lfsr;
    logic             in_load;
    logic             in_run;

    assign in_load = (state == LOAD);
    assign in_run  = (state == RUN);

    galois_reg #(
        .WIDTH     (WIDTH),
        .POLY      (POLY),
        .RESET_VAL (SEED)
    ) u_lfsr (
        .clock      (clock),
        .reset      (reset),
        .load       (in_load),
        .load_value (SEED),
        .step_en    (in_run),
        .xor_in     ('0),
        .value      (lfsr)
    );

    galois_reg #(
        .WIDTH     (WIDTH),
        .POLY      (POLY),
        .RESET_VAL ('0)
    ) u_misr (
        .clock      (clock),
        .reset      (reset),
        .load       (in_load),
        .load_value ('0),
        .step_en    (capture),
        .xor_in     (response),
        .value      (signature)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start only matters in IDLE and DONE.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = RUN;
            RUN:     if (count == LAST) state_next = FLUSH;
            FLUSH:   state_next = DONE;
            DONE:    if (start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    // Pattern counter plus the one-cycle-delayed capture strobe
    // that aligns MISR updates with the registered CUT responses.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count   <= '0;
            capture <= 1'b0;
        end else begin
            capture <= in_run;
            if (in_load) begin
                count <= '0;
            end else if (in_run) begin
                count <= count + 1'b1;
            end
        end
    end

    assign pattern = in_run ? lfsr : '0;
    assign busy    = in_load || in_run || (state == FLUSH);
    assign done    = (state == DONE);
    assign pass    = done && (signature == golden);

endmodule

// File: tb/tb_bist_misr_ctrl.sv
// Bench for bist_misr_ctrl at WIDTH=4, POLY=C, SEED=1.
// Three instances cover PATTERNS = 15, 3 and 1.
module tb_bist_misr_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instance A: PATTERNS=15, response tied low.
    logic       rst_a = 1'b0;
    logic       start_a = 1'b0;
    logic [3:0] pat_a, sig_a;
    logic       busy_a, done_a, pass_a;

    bist_misr_ctrl #(.WIDTH(4), .POLY(4'hC), .SEED(4'h1), .PATTERNS(15))
    u_a (
        .clock(clock), .reset(rst_a), .start(start_a), .golden(4'h0),
        .response(4'h0), .pattern(pat_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .signature(sig_a)
    );

    // Instance B: PATTERNS=3, loopback through a dff.
    logic       rst_b = 1'b0;
    logic       start_b = 1'b0;
    logic [3:0] gold_b = 4'h0;
    logic [3:0] pat_b, sig_b;
    logic [3:0] resp_b = 4'h0;
    logic       busy_b, done_b, pass_b;

    always @(posedge clock) resp_b <= pat_b;

    bist_misr_ctrl #(.WIDTH(4), .POLY(4'hC), .SEED(4'h1), .PATTERNS(3))
    u_b (
        .clock(clock), .reset(rst_b), .start(start_b), .golden(gold_b),
        .response(resp_b), .pattern(pat_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .signature(sig_b)
    );

    // Instance C: PATTERNS=1, loopback through a dff.
    logic       start_c = 1'b0;
    logic [3:0] pat_c, sig_c;
    logic [3:0] resp_c = 4'h0;
    logic       busy_c, done_c, pass_c;

    always @(posedge clock) resp_c <= pat_c;

    bist_misr_ctrl #(.WIDTH(4), .POLY(4'hC), .SEED(4'h1), .PATTERNS(1))
    u_c (
        .clock(clock), .reset(rst_a), .start(start_c), .golden(4'h1),
        .response(resp_c), .pattern(pat_c), .busy(busy_c), .done(done_c),
        .pass(pass_c), .signature(sig_c)
    );

    typedef struct {
        logic       rst;
        logic       start;
        logic [3:0] golden;
        logic       busy;
        logic       done;
        logic       pass;
        logic [3:0] pat;
        logic [3:0] sig;
        logic       sig_dc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic rst, logic st, logic [3:0] g,
                               logic b, logic d, logic p,
                               logic [3:0] pt, logic [3:0] s, logic dc);
        vec_t r;
        r.rst = rst; r.start = st; r.golden = g;
        r.busy = b; r.done = d; r.pass = p;
        r.pat = pt; r.sig = s; r.sig_dc = dc;
        return r;
    endfunction

    logic [3:0] exp_seq [15] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA,
                                 4'h5, 4'hE, 4'h7, 4'hF, 4'hB, 4'h9,
                                 4'h8, 4'h4, 4'h2};
    logic [3:0] got_seq [$];
    int         n;

    initial begin
        // rst st gold  busy done pass pat sig dc
        vecs.push_back(v(0, 0, 4'h6, 0, 0, 0, 4'h0, 4'h0, 0));
        vecs.push_back(v(1, 1, 4'h6, 1, 0, 0, 4'h0, 4'h0, 0));
        vecs.push_back(v(1, 1, 4'h6, 1, 0, 0, 4'h1, 4'h0, 0));
        vecs.push_back(v(1, 1, 4'h6, 1, 0, 0, 4'hC, 4'h0, 0));
        vecs.push_back(v(1, 1, 4'h6, 1, 0, 0, 4'h6, 4'h1, 0));
        vecs.push_back(v(1, 1, 4'h6, 1, 0, 0, 4'h0, 4'h0, 0));
        vecs.push_back(v(1, 0, 4'h6, 0, 1, 1, 4'h0, 4'h6, 0));
        vecs.push_back(v(1, 0, 4'h5, 0, 1, 0, 4'h0, 4'h6, 0));
        vecs.push_back(v(1, 1, 4'h6, 1, 0, 0, 4'h0, 4'h6, 1));
        vecs.push_back(v(1, 0, 4'h6, 1, 0, 0, 4'h1, 4'h0, 0));
        vecs.push_back(v(1, 0, 4'h6, 1, 0, 0, 4'hC, 4'h0, 0));
        vecs.push_back(v(1, 0, 4'h6, 1, 0, 0, 4'h6, 4'h1, 0));
        vecs.push_back(v(1, 0, 4'h6, 1, 0, 0, 4'h0, 4'h0, 0));
        vecs.push_back(v(1, 0, 4'h6, 0, 1, 1, 4'h0, 4'h6, 0));
        vecs.push_back(v(1, 1, 4'h6, 1, 0, 0, 4'h0, 4'h6, 1));
        vecs.push_back(v(1, 0, 4'h6, 1, 0, 0, 4'h1, 4'h0, 0));
        vecs.push_back(v(1, 0, 4'h6, 1, 0, 0, 4'hC, 4'h0, 0));
        vecs.push_back(v(0, 0, 4'h6, 0, 0, 0, 4'h0, 4'h0, 0));
        vecs.push_back(v(1, 0, 4'h6, 0, 0, 0, 4'h0, 4'h0, 0));
        vecs.push_back(v(0, 1, 4'h6, 0, 0, 0, 4'h0, 4'h0, 0));
        vecs.push_back(v(1, 0, 4'h6, 0, 0, 0, 4'h0, 4'h0, 0));
        vecs.push_back(v(1, 1, 4'h6, 1, 0, 0, 4'h0, 4'h0, 0));
        vecs.push_back(v(1, 0, 4'h6, 1, 0, 0, 4'h1, 4'h0, 0));
        vecs.push_back(v(1, 0, 4'h6, 1, 0, 0, 4'hC, 4'h0, 0));
        vecs.push_back(v(1, 0, 4'h6, 1, 0, 0, 4'h6, 4'h1, 0));
        vecs.push_back(v(1, 0, 4'h6, 1, 0, 0, 4'h0, 4'h0, 0));
        vecs.push_back(v(1, 0, 4'h6, 0, 1, 1, 4'h0, 4'h6, 0));

        // Reset state of instance A.
        repeat (2) @(posedge clock);
        #1;
        check("reset_a_outs", {busy_a, done_a, pass_a, pat_a},
              {3'b000, 4'h0});
        check("reset_a_sig", 32'(sig_a), 32'h0);

        // Table-driven run on instance B.
        foreach (vecs[i]) begin
            @(negedge clock);
            rst_b   = vecs[i].rst;
            start_b = vecs[i].start;
            gold_b  = vecs[i].golden;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d_ctl", i),
                  {busy_b, done_b, pass_b, pat_b},
                  {vecs[i].busy, vecs[i].done, vecs[i].pass, vecs[i].pat});
            if (!vecs[i].sig_dc)
                check($sformatf("vec%0d_sig", i), 32'(sig_b),
                      32'(vecs[i].sig));
        end

        // Reset pulse between edges while in DONE has no effect.
        @(negedge clock);
        rst_b = 1'b0;
        #2 rst_b = 1'b1;
        @(posedge clock);
        #1;
        check("glitch_done", 32'(done_b), 32'h1);
        check("glitch_sig", 32'(sig_b), 32'h6);

        // Instance A: full LFSR sequence and latency.
        @(negedge clock);
        rst_a   = 1'b1;
        start_a = 1'b1;
        n = 0;
        while (n < 40) begin
            @(posedge clock);
            #1;
            n++;
            start_a = 1'b0;
            if (pat_a != 4'h0) got_seq.push_back(pat_a);
            if (done_a) break;
        end
        check("a_latency", 32'(n), 32'd18);
        check("a_count", 32'(got_seq.size()), 32'd15);
        for (int i = 0; i < 15; i++) begin
            if (i < got_seq.size())
                check($sformatf("a_pat%0d", i), 32'(got_seq[i]),
                      32'(exp_seq[i]));
            else
                check($sformatf("a_pat%0d", i), 32'hX, 32'(exp_seq[i]));
        end
        check("a_sig", 32'(sig_a), 32'h0);

        // Instance C: single-pattern boundary.
        got_seq.delete();
        @(negedge clock);
        start_c = 1'b1;
        n = 0;
        while (n < 20) begin
            @(posedge clock);
            #1;
            n++;
            start_c = 1'b0;
            if (pat_c != 4'h0) got_seq.push_back(pat_c);
            if (done_c) break;
        end
        check("c_latency", 32'(n), 32'd4);
        check("c_count", 32'(got_seq.size()), 32'd1);
        if (got_seq.size() > 0)
            check("c_pat0", 32'(got_seq[0]), 32'h1);
        check("c_sig", 32'(sig_c), 32'h1);
        check("c_pass", 32'(pass_c), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
